nco_sweep_controller: RTL



---
 rtl/nco_pkg.sv | 28 ++
 rtl/nco_dwell_timer.sv | 36 +++
 rtl/nco_sweep_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// Shared definitions for the NCO control blocks: FSM state encoding, sweep direction,
// default tuning-word width and a ceil-log2 helper.
package nco_pkg;

  localparam int unsigned DefaultFtwWidth = 24;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StDwell = 2'd2,
    StDone  = 2'd3
  } nco_state_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } nco_dir_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/nco_dwell_timer.sv
// Load / decrement / zero-flag down-counter; saturates at zero.
module nco_dwell_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/nco_sweep_controller.sv
// Stepped-frequency sweep sequencer feeding tuning words to the NCO over valid/ready.
// Optional up-then-down sweep when NCO_SWEEP_PINGPONG_EN is defined.
module nco_sweep_controller
  import nco_pkg::*;
#(
  parameter int unsigned FTW_WIDTH   = DefaultFtwWidth,
  parameter int unsigned DWELL_WIDTH = 16,
  parameter int unsigned STEPS_WIDTH = 12
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [FTW_WIDTH-1:0]   cfg_start_ftw,
  input  logic [FTW_WIDTH-1:0]   cfg_step_ftw,
  input  logic [STEPS_WIDTH-1:0] cfg_num_steps,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  output logic [FTW_WIDTH-1:0]   ftw_out,
  output logic                   ftw_valid,
  input  logic                   ftw_ready,
  output logic [STEPS_WIDTH-1:0] step_idx,
  output logic                   busy,
  output logic                   done
);

  nco_state_e state_q, state_d;

  logic [FTW_WIDTH-1:0]   ftw_q, ftw_d;
  logic [FTW_WIDTH-1:0]   step_q, step_d;
  logic [STEPS_WIDTH-1:0] idx_q, idx_d;
  logic [STEPS_WIDTH-1:0] num_q, num_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;

  logic                   tmr_load, tmr_dec, tmr_zero;
  logic [DWELL_WIDTH-1:0] tmr_load_val;
  logic [DWELL_WIDTH-1:0] tmr_count;
  logic                   last_tone;
  logic                   capture;

  assign capture = (state_q == StIdle) && start && !abort;

  // A dwell of zero is held for one cycle, same as a dwell of one.
  assign tmr_load_val = (dwell_q == '0) ? '0 : dwell_q - DWELL_WIDTH'(1);

`ifdef NCO_SWEEP_PINGPONG_EN
  nco_dir_e dir_q, dir_d;

  // Peak tone is only terminal when there is nothing to descend through.
  assign last_tone = (dir_q == DirUp) ? ((idx_q == num_q) && (num_q == '0)) : (idx_q == '0);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      dir_q <= DirUp;
    end else begin
      dir_q <= dir_d;
    end
  end
`else
  assign last_tone = (idx_q == num_q);
`endif

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (capture) state_d = StLoad;
      StLoad: begin
        if (abort) begin
          state_d = StIdle;
        end else if (ftw_ready) begin
          state_d = StDwell;
        end
      end
      StDwell: begin
        if (abort) begin
          state_d = StIdle;
        end else if (tmr_zero) begin
          state_d = last_tone ? StDone : StLoad;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ftw_d    = ftw_q;
    step_d   = step_q;
    idx_d    = idx_q;
    num_d    = num_q;
    dwell_d  = dwell_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
`ifdef NCO_SWEEP_PINGPONG_EN
    dir_d    = dir_q;
`endif
    if (capture) begin
      ftw_d   = cfg_start_ftw;
      step_d  = cfg_step_ftw;
      idx_d   = '0;
      num_d   = cfg_num_steps;
      dwell_d = cfg_dwell;
`ifdef NCO_SWEEP_PINGPONG_EN
      dir_d   = DirUp;
`endif
    end
    if ((state_q == StLoad) && !abort && ftw_ready) begin
      tmr_load = 1'b1;
    end
    if ((state_q == StDwell) && !abort) begin
      tmr_dec = 1'b1;
      if (tmr_zero && !last_tone) begin
`ifdef NCO_SWEEP_PINGPONG_EN
        if ((dir_q == DirUp) && (idx_q != num_q)) begin
          ftw_d = ftw_q + step_q;
          idx_d = idx_q + STEPS_WIDTH'(1);
        end else begin
          dir_d = DirDown;
          ftw_d = ftw_q - step_q;
          idx_d = idx_q - STEPS_WIDTH'(1);
        end
`else
        ftw_d = ftw_q + step_q;
        idx_d = idx_q + STEPS_WIDTH'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      ftw_q   <= '0;
      step_q  <= '0;
      idx_q   <= '0;
      num_q   <= '0;
      dwell_q <= '0;
    end else begin
      ftw_q   <= ftw_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      dwell_q <= dwell_d;
    end
  end

  nco_dwell_timer #(
    .WIDTH(DWELL_WIDTH)
  ) u_dwell_timer (
    .clk_in  (clk_in),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_load_val),
    .dec     (tmr_dec),
    .count   (tmr_count),
    .zero    (tmr_zero)
  );

  always_comb begin
    ftw_out   = ftw_q;
    step_idx  = idx_q;
    ftw_valid = (state_q == StLoad);
    busy      = (state_q == StLoad) || (state_q == StDwell);
    done      = (state_q == StDone);
  end

  logic unused_count;
  assign unused_count = ^tmr_count;

endmodule
